servant_rst_seq: RTL
====================

// Module: servant_rst_seq
// PURPOSE
//  Reset sequencer fed by the servant clock generator's o_clk/o_rst (or any raw async reset).
//  Synchronises reset release to i_clk, then releases memory-side and CPU-side resets in order.
//  Supports a CPU-only soft reset and reports the cause of the last reset.
//  Sits between clock generation and the servant SoC top (RAM/peripherals first, then the SERV core).
// PARAMETERS
//  SYNC_STAGES  2        flops in the reset-release synchroniser (>=2)
//  MEM_HOLD     16       cycles o_rst_mem is held after synchronised release (>=1)
//  CPU_HOLD     16       cycles o_rst_cpu is held after o_rst_mem drops (>=1)
//  WDT_CYCLES   1<<20    watchdog timeout in cycles (used only with SERVANT_RST_WDT_EN)
//  Elaboration error if MEM_HOLD==0, CPU_HOLD==0 or SYNC_STAGES<2.
// PORTS
//  i_clk       in   1  single clock for the block (o_clk of the clock generator)
//  i_rst       in   1  reset; asynchronous, active-high
//  i_soft_rst  in   1  synchronous CPU soft-reset request, level-sampled
//  i_wdt_kick  in   1  watchdog kick, one-cycle pulse; ignored without SERVANT_RST_WDT_EN
//  o_rst_mem   out  1  reset to RAM/peripherals, active-high, registered
//  o_rst_cpu   out  1  reset to the CPU core, active-high, registered
//  o_ready     out  1  high only in RUN
//  o_cause     out  2  last reset cause: 00 power-on/i_rst, 01 soft, 10 watchdog
// BEHAVIOUR
//  i_rst high: asynchronously force state RESET, synchroniser all-ones, counters 0,
//   o_rst_mem=1, o_rst_cpu=1, o_ready=0, o_cause=00. Nothing released while i_rst is high.
//  Release: synchroniser asserts asynchronously and deasserts through SYNC_STAGES flops.
//  FSM states: RESET -> HOLD_MEM -> HOLD_CPU -> RUN.
//   RESET:    exit to HOLD_MEM on the first edge the synchroniser output is 0; cnt=0.
//   HOLD_MEM: cnt++ each cycle; at cnt==MEM_HOLD-1 -> HOLD_CPU, cnt=0, o_rst_mem<=0.
//   HOLD_CPU: cnt++; at cnt==CPU_HOLD-1 -> RUN, o_rst_cpu<=0, o_ready<=1.
//   RUN:      steady state; all outputs stable.
//  Latency from the first i_clk edge with i_rst low:
//   o_rst_mem falls after exactly SYNC_STAGES+MEM_HOLD+1 edges.
//   o_rst_cpu and o_ready change CPU_HOLD edges after o_rst_mem falls.
//  Soft reset: i_soft_rst high at an edge in HOLD_CPU or RUN -> next cycle HOLD_CPU, cnt=0,
//   o_rst_cpu=1, o_ready=0, o_cause=01; o_rst_mem stays 0 so memory contents are kept.
//   Ignored in RESET/HOLD_MEM. If held high, cnt restarts every cycle; release after deassert.
//  Counter width $clog2(max(MEM_HOLD,CPU_HOLD)+1); no wrap (cleared on every transition).
//  i_rst asserting mid-sequence, including mid-soft-reset: immediate async return to RESET.
// CONFIGURATION
//  SERVANT_RST_WDT_EN defined:
//   Watchdog counter runs only in RUN; i_wdt_kick clears it to 0.
//   At cnt==WDT_CYCLES-1 with no kick: same action as soft reset, but o_cause=10.
//   Counter cleared outside RUN. Soft reset and timeout on the same edge: soft wins, o_cause=01.
//  Not defined: no watchdog logic, i_wdt_kick unused, o_cause never 10.
// STRUCTURE
//  Package servant_rst_pkg holds:
//   state enum (RESET, HOLD_MEM, HOLD_CPU, RUN)
//   cause constants CAUSE_POR=2'b00, CAUSE_SOFT=2'b01, CAUSE_WDT=2'b10
//  Sub-module servant_rst_sync: async-assert/sync-deassert SYNC_STAGES-flop synchroniser.
//  FSM, hold counter and optional watchdog live in servant_rst_seq.
// TESTING (SYNC_STAGES=2, MEM_HOLD=4, CPU_HOLD=3, WDT_CYCLES=8)
//  POR: i_rst 1->0 -> o_rst_mem falls at edge 7; o_rst_cpu=0 and o_ready=1 at edge 10; o_cause=00.
//  Soft reset: 1-cycle i_soft_rst in RUN -> o_rst_cpu=1, o_ready=0 next cycle for 3 cycles.
//   o_rst_mem stays 0; o_cause=01.
//  Mid-sequence reset: i_rst pulse at edge 8 (HOLD_CPU) -> all resets 1 asynchronously.
//   Sequence restarts with identical timing.
//  Held soft reset: i_soft_rst high for 10 cycles -> o_rst_cpu stays high; drops 3 cycles after release.
//  WDT_EN, no kick: o_rst_cpu asserts 8 cycles after entering RUN; o_cause=10.
//  WDT_EN, kick every 5 cycles: no reset; kick and i_soft_rst on timeout edge -> o_cause=01.

Source files
------------

// File: rtl/servant_rst_pkg.sv
// servant_rst_pkg
// Shared definitions for the servant reset sequencer:
//   state_e     - sequencer FSM states (RESET, HOLD_MEM, HOLD_CPU, RUN)
//   CAUSE_*     - encodings reported on o_cause
//   max_int()   - elaboration-time helper used to size the hold counter
package servant_rst_pkg;

  typedef enum logic [1:0] {
    RESET    = 2'b00,
    HOLD_MEM = 2'b01,
    HOLD_CPU = 2'b10,
    RUN      = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servant_rst_sync.sv
// servant_rst_sync
// Reset-release synchroniser: assertion is asynchronous, deassertion is
// clocked through STAGES flops so the released reset is safe in i_clk.
// Ports:
//   i_clk  in  1  destination clock
//   i_rst  in  1  raw reset, asynchronous, active-high
//   o_rst  out 1  synchronised reset, active-high (direct flop output)
module servant_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst
);

  logic [STAGES-1:0] sync_q;

  // Shift chain: all-ones on reset, zeros walk in once i_rst drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end
  end

  assign o_rst = sync_q[STAGES-1];

endmodule

// File: rtl/servant_rst_seq.sv
// servant_rst_seq
// Reset sequencer for the servant SoC. Synchronises release of i_rst to
// i_clk, then drops the memory-side reset followed by the CPU-side reset.
// A CPU-only soft reset keeps RAM/peripherals out of reset so memory
// contents survive. o_cause reports why the CPU was last reset.
//
// Optional feature: define SERVANT_RST_WDT_EN to add a watchdog that
// performs a CPU-only reset (o_cause=10) after WDT_CYCLES cycles in RUN
// without an i_wdt_kick pulse. Without it, i_wdt_kick is unused.
//
// Ports:
//   i_clk       in  1  block clock
//   i_rst       in  1  asynchronous active-high reset
//   i_soft_rst  in  1  synchronous CPU soft-reset request (level)
//   i_wdt_kick  in  1  watchdog kick pulse
//   o_rst_mem   out 1  RAM/peripheral reset, active-high, registered
//   o_rst_cpu   out 1  CPU reset, active-high, registered
//   o_ready     out 1  high only in RUN
//   o_cause     out 2  last reset cause (00 POR, 01 soft, 10 watchdog)
module servant_rst_seq
  import servant_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_HOLD    = 16,
  parameter int CPU_HOLD    = 16,
  parameter int WDT_CYCLES  = 1 << 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_soft_rst,
  input  logic       i_wdt_kick,
  output logic       o_rst_mem,
  output logic       o_rst_cpu,
  output logic       o_ready,
  output logic [1:0] o_cause
);

  localparam int CNT_W = $clog2(max_int(MEM_HOLD, CPU_HOLD) + 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_HOLD - 1);
  localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_HOLD - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("servant_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (MEM_HOLD < 1) begin : g_bad_mem_hold
    $error("servant_rst_seq: MEM_HOLD must be >= 1");
  end
  if (CPU_HOLD < 1) begin : g_bad_cpu_hold
    $error("servant_rst_seq: CPU_HOLD must be >= 1");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rst_mem_q;
  logic             rst_cpu_q;
  logic             ready_q;
  logic [1:0]       cause_q;

  logic rst_sync_s;
  logic soft_ok_s;
  logic wdt_timeout_s;

  servant_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_rst (rst_sync_s)
  );

  // Soft reset only acts once memory is out of reset.
  assign soft_ok_s = (state_q == HOLD_CPU) || (state_q == RUN);

`ifdef SERVANT_RST_WDT_EN
  localparam int WDT_W = max_int($clog2(WDT_CYCLES), 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q;

  // A kick on the expiry edge clears the count instead of timing out.
  assign wdt_timeout_s = (state_q == RUN) && !i_wdt_kick && (wdt_q == WDT_LAST);

  // Watchdog counter: counts only in RUN, cleared by kick or on expiry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdt_q <= '0;
    end else if (state_q != RUN) begin
      wdt_q <= '0;
    end else if (i_wdt_kick || (wdt_q == WDT_LAST)) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_q + WDT_W'(1);
    end
  end
`else
  logic unused_wdt_kick_s;
  assign unused_wdt_kick_s = i_wdt_kick;
  assign wdt_timeout_s     = 1'b0;
`endif

  // Sequencer FSM with hold counter and registered outputs. Soft reset is
  // checked before the watchdog so it wins when both hit the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= RESET;
      cnt_q     <= '0;
      rst_mem_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else if (soft_ok_s && i_soft_rst) begin
      state_q   <= HOLD_CPU;
      cnt_q     <= '0;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_SOFT;
    end else if (wdt_timeout_s) begin
      state_q   <= HOLD_CPU;
      cnt_q     <= '0;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_WDT;
    end else begin
      case (state_q)
        RESET: begin
          cnt_q <= '0;
          if (!rst_sync_s) begin
            state_q <= HOLD_MEM;
          end else begin
            state_q <= RESET;
          end
        end
        HOLD_MEM: begin
          if (cnt_q == MEM_LAST) begin
            state_q   <= HOLD_CPU;
            cnt_q     <= '0;
            rst_mem_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD_CPU: begin
          if (cnt_q == CPU_LAST) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            rst_cpu_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        default: begin
          state_q   <= RESET;
          cnt_q     <= '0;
          rst_mem_q <= 1'b1;
          rst_cpu_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rst_mem = rst_mem_q;
  assign o_rst_cpu = rst_cpu_q;
  assign o_ready   = ready_q;
  assign o_cause   = cause_q;

endmodule
